// File: rtl/trig_accept.sv
// Trigger acceptor: edge-detects trig_in, gates an acquisition window, latches event number/timestamp, hands off to readout.
// Latency: acq_win rises one cycle after the accepted edge; evt_valid rises max(win_len,1)+1 cycles after the edge.
// Backpressure: evt_valid holds the record until rd_ack; trigger_stun stays high while busy and edges seen then count as lost.
module trig_accept #(
  parameter int WIN_W  = 12,
  parameter int HOLD_W = 8,
  parameter int TS_W   = 48,
  parameter int EVT_W  = 24,
  parameter int LOST_W = 16
) (
  input  logic              init_clk,
  input  logic              reset_i,
  input  logic              enable,
  input  logic              trig_in,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              rd_ack,
  input  logic              clr_cnt,
  output logic              trigger_stun,
  output logic              acq_win,
  output logic              evt_valid,
  output logic [EVT_W-1:0]  evt_num,
  output logic [TS_W-1:0]   evt_ts,
  output logic [LOST_W-1:0] lost_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WINDOW  = 2'd1,
    S_WAIT_RD = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                trig_d_q;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [EVT_W-1:0]    evt_cnt_q, evt_cnt_d;
  logic [LOST_W-1:0]   lost_q, lost_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [EVT_W-1:0]    evt_num_q, evt_num_d;
  logic [TS_W-1:0]     evt_ts_q, evt_ts_d;
  logic                stun_q, acq_q, valid_q;

  logic                trig_edge;
  logic                trig_take;
  logic                trig_lost;
  logic                evt_done;

  // A held-high trigger produces one edge because we compare against last cycle's level.
  assign trig_edge = trig_in & ~trig_d_q;
  assign trig_take = trig_edge & enable & (state_q == S_IDLE);
  assign trig_lost = trig_edge & enable & (state_q != S_IDLE);

  // Next-state logic; window and holdoff counters count down to 1 then leave.
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    hold_cnt_d = hold_cnt_q;
    evt_num_d  = evt_num_q;
    evt_ts_d   = evt_ts_q;
    evt_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_take) begin
          state_d   = S_WINDOW;
          evt_ts_d  = ts_q;
          evt_num_d = evt_cnt_q;
          // A zero length still opens a one-cycle window.
          win_cnt_d = (win_len == '0) ? WIN_W'(1) : win_len;
        end
      end
      S_WINDOW: begin
        if (win_cnt_q <= WIN_W'(1)) begin
          state_d = S_WAIT_RD;
        end else begin
          win_cnt_d = win_cnt_q - WIN_W'(1);
        end
      end
      S_WAIT_RD: begin
        if (rd_ack) begin
          evt_done = 1'b1;
          if (holdoff != '0) begin
            state_d    = S_HOLDOFF;
            hold_cnt_d = holdoff;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLDOFF: begin
        if (hold_cnt_q <= HOLD_W'(1)) begin
          state_d = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Free-running counters; a clear wins over any increment in the same cycle.
  always_comb begin
    ts_d      = clr_cnt ? '0 : ts_q + TS_W'(1);
    evt_cnt_d = evt_cnt_q;
    lost_d    = lost_q;
    if (clr_cnt) begin
      evt_cnt_d = '0;
      lost_d    = '0;
    end else begin
      if (evt_done) begin
        evt_cnt_d = evt_cnt_q + EVT_W'(1);
      end
      if (trig_lost && (lost_q != {LOST_W{1'b1}})) begin
        lost_d = lost_q + LOST_W'(1);
      end
    end
  end

  // State, counters and registered outputs; reset aborts any event in flight.
  always_ff @(posedge init_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      trig_d_q   <= 1'b0;
      ts_q       <= '0;
      evt_cnt_q  <= '0;
      lost_q     <= '0;
      win_cnt_q  <= '0;
      hold_cnt_q <= '0;
      evt_num_q  <= '0;
      evt_ts_q   <= '0;
      stun_q     <= 1'b0;
      acq_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_d_q   <= trig_in;
      ts_q       <= ts_d;
      evt_cnt_q  <= evt_cnt_d;
      lost_q     <= lost_d;
      win_cnt_q  <= win_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      evt_num_q  <= evt_num_d;
      evt_ts_q   <= evt_ts_d;
      stun_q     <= (state_d != S_IDLE);
      acq_q      <= (state_d == S_WINDOW);
      valid_q    <= (state_d == S_WAIT_RD);
    end
  end

  assign trigger_stun = stun_q;
  assign acq_win      = acq_q;
  assign evt_valid    = valid_q;
  assign evt_num      = evt_num_q;
  assign evt_ts       = evt_ts_q;
  assign lost_cnt     = lost_q;

endmodule

// File: tb/tb_trig_accept.sv
// Directed bench for trig_accept: window timing, handshake, lost counting, holdoff, reset, saturation.
// Lost counter is narrowed so saturation can be reached in a short run.
// Inputs are driven 1 time unit after each rising edge; outputs are checked there too.
module tb_trig_accept;

  localparam int LW = 10;

  logic          init_clk = 1'b0;
  logic          reset_i;
  logic          enable;
  logic          trig_in;
  logic [11:0]   win_len;
  logic [7:0]    holdoff;
  logic          rd_ack;
  logic          clr_cnt;
  logic          trigger_stun;
  logic          acq_win;
  logic          evt_valid;
  logic [23:0]   evt_num;
  logic [47:0]   evt_ts;
  logic [LW-1:0] lost_cnt;

  int            total = 0;
  int            bad   = 0;
  logic [47:0]   ts_m  = '0;
  logic [47:0]   last_ts;
  logic [47:0]   ev_ts;
  int            nev;
  logic          prev_v;

  trig_accept #(.LOST_W(LW)) dut (
    .init_clk     (init_clk),
    .reset_i      (reset_i),
    .enable       (enable),
    .trig_in      (trig_in),
    .win_len      (win_len),
    .holdoff      (holdoff),
    .rd_ack       (rd_ack),
    .clr_cnt      (clr_cnt),
    .trigger_stun (trigger_stun),
    .acq_win      (acq_win),
    .evt_valid    (evt_valid),
    .evt_num      (evt_num),
    .evt_ts       (evt_ts),
    .lost_cnt     (lost_cnt)
  );

  always #5 init_clk = ~init_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the timestamp model follows the values the DUT samples at this edge.
  task automatic tick();
    @(posedge init_clk);
    ts_m = (reset_i || clr_cnt) ? 48'd0 : ts_m + 48'd1;
    #1;
  endtask

  // One-cycle trigger pulse; remembers the timestamp at the edge cycle.
  task automatic pulse();
    last_ts = ts_m;
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (evt_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, evt_valid, 1);
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; enable = 1'b0; trig_in = 1'b0; win_len = 12'd0;
    holdoff = 8'd0; rd_ack = 1'b0; clr_cnt = 1'b0;
    #100;
    chk("rst_stun", trigger_stun, 0);
    chk("rst_acq", acq_win, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_num", evt_num, 0);
    chk("rst_ts", evt_ts, 0);
    chk("rst_lost", lost_cnt, 0);
    tick();
    reset_i = 1'b0;

    // 1: single pulse at ts=20, four-cycle window
    enable = 1'b1; win_len = 12'd4; holdoff = 8'd0;
    repeat (20) tick();
    pulse();
    for (int i = 0; i < 4; i++) begin
      chk("t1_acq_on", acq_win, 1);
      chk("t1_valid_off", evt_valid, 0);
      chk("t1_stun_on", trigger_stun, 1);
      tick();
    end
    chk("t1_acq_off", acq_win, 0);
    chk("t1_valid", evt_valid, 1);
    chk("t1_ts", evt_ts, 20);
    chk("t1_num", evt_num, 0);
    ack();
    chk("t1_valid_clr", evt_valid, 0);
    chk("t1_stun_clr", trigger_stun, 0);

    // 2: trigger held high for 50 cycles yields exactly one event
    trig_in = 1'b1; nev = 0; prev_v = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rd_ack = evt_valid;
      tick();
      if (evt_valid && !prev_v) nev++;
      prev_v = evt_valid;
    end
    trig_in = 1'b0; rd_ack = 1'b0;
    tick();
    chk("t2_events", nev, 1);
    chk("t2_lost", lost_cnt, 0);
    chk("t2_stun", trigger_stun, 0);
    chk("t2_num", evt_num, 1);

    // 3: clear counters, then edges during WINDOW and WAIT_RD are lost
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t3_num_kept", evt_num, 1);
    repeat (5) tick();
    pulse();
    tick();
    pulse();
    chk("t3_lost_win", lost_cnt, 1);
    chk("t3_stun_win", trigger_stun, 1);
    chk("t3_acq_win", acq_win, 1);
    wait_valid("t3_valid");
    pulse();
    chk("t3_lost_rd", lost_cnt, 2);
    chk("t3_stun_rd", trigger_stun, 1);
    chk("t3_valid_held", evt_valid, 1);
    chk("t3_ts", evt_ts, 5);
    chk("t3_num0", evt_num, 0);
    ack();
    chk("t3_stun_clr", trigger_stun, 0);
    pulse();
    wait_valid("t3_valid2");
    chk("t3_num1", evt_num, 1);
    ack();

    // 4: holdoff of 10 cycles after ack at cycle A
    holdoff = 8'd10; win_len = 12'd2;
    pulse();
    wait_valid("t4_valid");
    ack();
    chk("t4_stun_a1", trigger_stun, 1);
    chk("t4_valid_a1", evt_valid, 0);
    repeat (4) tick();
    pulse();
    chk("t4_lost", lost_cnt, 3);
    chk("t4_no_acq", acq_win, 0);
    repeat (4) tick();
    chk("t4_stun_a10", trigger_stun, 1);
    tick();
    chk("t4_stun_a11", trigger_stun, 0);
    pulse();
    chk("t4_acq_acc", acq_win, 1);
    chk("t4_stun_acc", trigger_stun, 1);
    chk("t4_lost_same", lost_cnt, 3);
    wait_valid("t4_valid2");
    chk("t4_num", evt_num, 3);
    holdoff = 8'd0;
    ack();

    // 5: zero window length, readout delayed 30 cycles
    win_len = 12'd0;
    pulse();
    chk("t5_acq1", acq_win, 1);
    tick();
    chk("t5_acq0", acq_win, 0);
    chk("t5_valid", evt_valid, 1);
    chk("t5_ts", evt_ts, last_ts);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("t5_valid_hold", evt_valid, 1);
      chk("t5_ts_hold", evt_ts, last_ts);
    end
    chk("t5_num", evt_num, 4);
    ack();
    chk("t5_valid_clr", evt_valid, 0);

    // 6: reset during WINDOW, disabled edges, enable drop, lost saturation, clear priority
    win_len = 12'd4;
    pulse();
    tick();
    reset_i = 1'b1;
    #1;
    chk("t6_rst_stun", trigger_stun, 0);
    chk("t6_rst_acq", acq_win, 0);
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_num", evt_num, 0);
    chk("t6_rst_ts", evt_ts, 0);
    chk("t6_rst_lost", lost_cnt, 0);
    tick();
    reset_i = 1'b0;
    tick();
    pulse();
    ev_ts = last_ts;
    enable = 1'b0;
    repeat (3) begin
      pulse();
      tick();
    end
    chk("t6_dis_lost", lost_cnt, 0);
    chk("t6_dis_stun", trigger_stun, 1);
    wait_valid("t6_valid");
    chk("t6_num", evt_num, 0);
    chk("t6_ts", evt_ts, ev_ts);
    enable = 1'b1;
    repeat (1022) begin
      pulse();
      tick();
    end
    chk("t6_lost_1022", lost_cnt, 1022);
    pulse();
    tick();
    chk("t6_lost_max", lost_cnt, 1023);
    repeat (2) begin
      pulse();
      tick();
    end
    chk("t6_lost_sat", lost_cnt, 1023);
    clr_cnt = 1'b1; trig_in = 1'b1;
    tick();
    clr_cnt = 1'b0; trig_in = 1'b0;
    chk("t6_clr_prio", lost_cnt, 0);
    chk("t6_clr_num", evt_num, 0);
    chk("t6_clr_ts", evt_ts, ev_ts);
    chk("t6_clr_valid", evt_valid, 1);
    ack();
    chk("t6_stun_end", trigger_stun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
